// File: rtl/program_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : program_counter_if                                               |
// | Purpose  : Control/load bundle between the datapath sequencer and the PC.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface program_counter_if;
    logic [7:0] adl_in;
    logic [7:0] adh_in;
    logic       ladl;
    logic       ladh;
    logic       inc;
    logic       opcl_al;
    logic       opch_ah;
    logic       opcl_db;
    logic       opch_db;
    logic       pgx;
    logic       pcwrap;

    modport master (
        output adl_in, adh_in, ladl, ladh, inc,
        output opcl_al, opch_ah, opcl_db, opch_db,
        input  pgx, pcwrap
    );

    modport slave (
        input  adl_in, adh_in, ladl, ladh, inc,
        input  opcl_al, opch_ah, opcl_db, opch_db,
        output pgx, pcwrap
    );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : program_counter                                                  |
// | Purpose  : 6502 PCL/PCH register with load, increment and tristate drives.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module program_counter #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    program_counter_if.slave bus,
    // Tristate buses stay plain ports so the resolution happens at the bus wire.
    output wire [7:0]       addrlow,
    output wire [7:0]       addrhi,
    output wire [7:0]       databs
);

    logic [7:0] r_pcl;
    logic [7:0] r_pch;
    logic       r_pgx;
    logic       r_pcwrap;

    logic [7:0] w_lo_src;
    logic [7:0] w_hi_src;
    logic [8:0] w_lo_sum;
    logic       w_carry;
    logic [7:0] w_hi_next;
    logic       w_wrap;

    // Loads select the source first; the increment applies to the selected value.
    always_comb begin
        w_lo_src  = bus.ladl ? bus.adl_in : r_pcl;
        w_hi_src  = bus.ladh ? bus.adh_in : r_pch;
        w_lo_sum  = {1'b0, w_lo_src} + {8'h00, bus.inc};
        w_carry   = w_lo_sum[8];
        w_hi_next = w_hi_src + {7'b0, w_carry};
        w_wrap    = w_carry & (w_hi_src == 8'hFF);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pcl    <= RESET_PC[7:0];
            r_pch    <= RESET_PC[15:8];
            r_pgx    <= 1'b0;
            r_pcwrap <= 1'b0;
        end else begin
            r_pcl    <= w_lo_sum[7:0];
            r_pch    <= w_hi_next;
            r_pgx    <= w_carry;
            r_pcwrap <= w_wrap;
        end
    end

    assign bus.pgx    = r_pgx;
    assign bus.pcwrap = r_pcwrap;

    // PCL wins the data bus if both DB enables are raised together.
    assign addrlow = bus.opcl_al ? r_pcl : 8'hzz;
    assign addrhi  = bus.opch_ah ? r_pch : 8'hzz;
    assign databs  = bus.opcl_db ? r_pcl : (bus.opch_db ? r_pch : 8'hzz);

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// Bench for program_counter: scoreboard of expected PC/flags per clock edge,
// plus direct checks of the combinational tristate drives.
module tb_program_counter;

    typedef struct packed {
        logic [15:0] pc;
        logic        pgx;
        logic        wrap;
    } exp_t;

    logic       clk;
    logic       rstn;
    wire  [7:0] addrlow;
    wire  [7:0] addrhi;
    wire  [7:0] databs;

    program_counter_if pc_bus ();

    program_counter #(.RESET_PC(16'hFFFC)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (pc_bus),
        .addrlow (addrlow),
        .addrhi  (addrhi),
        .databs  (databs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic [15:0] m_pc;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Model next-state, push expectation, apply one edge, pop and compare.
    task automatic pc_cycle(input logic l_lo, input logic l_hi, input logic l_inc,
                            input logic [7:0] a_lo, input logic [7:0] a_hi);
        logic [7:0] lo_src, hi_src, hi_nx;
        logic [8:0] sum;
        exp_t e, got;
        lo_src = l_lo ? a_lo : m_pc[7:0];
        hi_src = l_hi ? a_hi : m_pc[15:8];
        sum    = {1'b0, lo_src} + {8'h00, l_inc};
        hi_nx  = hi_src + {7'b0, sum[8]};
        e.pc   = {hi_nx, sum[7:0]};
        e.pgx  = sum[8];
        e.wrap = sum[8] && (hi_src == 8'hFF);
        sb.push_back(e);
        m_pc = e.pc;
        pc_bus.ladl   = l_lo;
        pc_bus.ladh   = l_hi;
        pc_bus.inc    = l_inc;
        pc_bus.adl_in = a_lo;
        pc_bus.adh_in = a_hi;
        @(posedge clk);
        #1;
        check_val("sb_nonempty", (sb.size() > 0) ? 16'd1 : 16'd0, 16'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check_val("pc",     {addrhi, addrlow},          got.pc);
            check_val("pgx",    {15'b0, pc_bus.pgx},        {15'b0, got.pgx});
            check_val("pcwrap", {15'b0, pc_bus.pcwrap},     {15'b0, got.wrap});
        end
    endtask

    task automatic check_z(input string tag, input logic is_z);
        check_val(tag, {15'b0, is_z}, 16'd1);
    endtask

    initial begin
        pc_bus.ladl = 0; pc_bus.ladh = 0; pc_bus.inc = 0;
        pc_bus.adl_in = 8'h00; pc_bus.adh_in = 8'h00;
        pc_bus.opcl_al = 1; pc_bus.opch_ah = 1;
        pc_bus.opcl_db = 0; pc_bus.opch_db = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check_val("rst_addrlow", {8'h00, addrlow}, 16'h00FC);
        check_val("rst_addrhi",  {8'h00, addrhi},  16'h00FF);
        check_val("rst_pgx",     {15'b0, pc_bus.pgx},    16'd0);
        check_val("rst_pcwrap",  {15'b0, pc_bus.pcwrap}, 16'd0);
        pc_bus.opcl_al = 0; pc_bus.opch_ah = 0;
        #1;
        check_z("rst_addrlow_z", addrlow === 8'hzz);
        check_z("rst_addrhi_z",  addrhi  === 8'hzz);
        check_z("rst_databs_z",  databs  === 8'hzz);
        pc_bus.opcl_al = 1; pc_bus.opch_ah = 1;
        // Reset held across an edge must keep RESET_PC.
        @(posedge clk); #1;
        check_val("rst_hold", {addrhi, addrlow}, 16'hFFFC);
        @(negedge clk) rstn = 1'b1;
        m_pc = 16'hFFFC;

        // Sequential fetch across a page boundary.
        pc_cycle(1, 1, 0, 8'hFE, 8'h80);
        pc_cycle(0, 0, 1, 8'h00, 8'h00);
        pc_cycle(0, 0, 1, 8'h00, 8'h00);
        pc_cycle(0, 0, 1, 8'h00, 8'h00);

        // Jump, then increment.
        pc_cycle(1, 1, 0, 8'h34, 8'h12);
        pc_cycle(0, 0, 1, 8'h00, 8'h00);

        // Load with increment carrying into freshly loaded PCH.
        pc_cycle(1, 1, 1, 8'hFF, 8'h12);

        // Full wrap, then hold clears flags.
        pc_cycle(1, 1, 0, 8'hFF, 8'hFF);
        pc_cycle(0, 0, 1, 8'h00, 8'h00);
        pc_cycle(0, 0, 0, 8'h00, 8'h00);

        // DB drive and conflict priority.
        pc_cycle(1, 1, 0, 8'hCD, 8'hAB);
        pc_bus.opch_db = 1; #1;
        check_val("db_pch",  {8'h00, databs}, 16'h00AB);
        pc_bus.opcl_db = 1; #1;
        check_val("db_both", {8'h00, databs}, 16'h00CD);
        pc_bus.opch_db = 0; #1;
        check_val("db_pcl",  {8'h00, databs}, 16'h00CD);
        pc_bus.opcl_db = 0; #1;
        check_z("db_none_z", databs === 8'hzz);

        // Loading from ADL while driving it: old value until the edge.
        pc_bus.ladl = 1; pc_bus.adl_in = 8'h55; #1;
        check_val("rd_ld_old", {8'h00, addrlow}, 16'h00CD);
        pc_cycle(1, 0, 0, 8'h55, 8'h00);

        // Random mix of loads, increments and DB reads.
        for (int i = 0; i < 40; i++) begin
            logic cl, ch;
            cl = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            pc_bus.opcl_db = cl; pc_bus.opch_db = ch; #1;
            if (cl)      check_val("rnd_db", {8'h00, databs}, {8'h00, m_pc[7:0]});
            else if (ch) check_val("rnd_db", {8'h00, databs}, {8'h00, m_pc[15:8]});
            else         check_z("rnd_db_z", databs === 8'hzz);
            pc_bus.opcl_db = 0; pc_bus.opch_db = 0;
            pc_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) != 0),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges, then normal operation resumes.
        pc_cycle(1, 1, 0, 8'h10, 8'h20);
        pc_bus.inc = 1;
        #2 rstn = 1'b0;
        #1;
        check_val("async_rst_pc",  {addrhi, addrlow},       16'hFFFC);
        check_val("async_rst_pgx", {15'b0, pc_bus.pgx},     16'd0);
        @(negedge clk) rstn = 1'b1;
        m_pc = 16'hFFFC;
        pc_cycle(0, 0, 1, 8'h00, 8'h00);

        check_val("sb_drained", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter (PCL/PCH) for the 6502 datapath, directly downstream of the input data latch.
- Captures jump/vector targets from the internal ADL and ADH buses, which the latch drives, and increments for sequential fetch.
- Drives its halves back onto ADL, ADH or DB through tristate outputs, in the same bus-sharing style as the latch.

Parameters:
- RESET_PC, 16'hFFFC: PC value loaded on reset (reset-vector low-byte address).

Ports:
- clk  input  1  system clock (phi2); all state updates on posedge.
- rstn  input  1  asynchronous, active-low reset.
- adl_in  input  8  ADL bus value (load source for PCL).
- adh_in  input  8  ADH bus value (load source for PCH).
- ladl  input  1  load PCL from adl_in.
- ladh  input  1  load PCH from adh_in.
- inc  input  1  increment PC by 1 (after load selection).
- opcl_al  input  1  drive PCL onto addrlow.
- opch_ah  input  1  drive PCH onto addrhi.
- opcl_db  input  1  drive PCL onto databs.
- opch_db  input  1  drive PCH onto databs.
- addrlow  output  8  ADL bus drive; 8'hzz when opcl_al=0.
- addrhi  output  8  ADH bus drive; 8'hzz when opch_ah=0.
- databs  output  8  DB bus drive; 8'hzz when neither DB enable is set.
- pgx  output  1  registered flag: the last update carried from PCL into PCH.
- pcwrap  output  1  registered flag: the last update wrapped 16'hFFFF to 16'h0000.

Behaviour:
- Reset (rstn=0, asynchronous, regardless of clk): {PCH,PCL}=RESET_PC, pgx=0, pcwrap=0. Held while rstn=0.
- Tristate outputs stay combinational on the enables during reset, so addrlow shows RESET_PC[7:0] if opcl_al=1.
- Next-state computation, evaluated at each posedge clk with rstn=1:
  - lo_src = ladl ? adl_in : PCL; hi_src = ladh ? adh_in : PCH.
  - {c, lo_next} = lo_src + inc (9-bit sum).
  - hi_next = hi_src + c (8-bit, wraps modulo 256).
  - PCL <= lo_next; PCH <= hi_next.
- Loads take effect first; inc applies to the selected value. ladl=1, inc=1, adl_in=8'hFF yields PCL=00 and carries into hi_src.
- Carry propagates into a freshly loaded PCH: ladh=1, adh_in=8'h12, ladl=1, adl_in=8'hFF, inc=1 gives PC=16'h1300.
- No load and no inc: PC holds; pgx and pcwrap clear to 0.
- pgx <= c on every clock.
- pcwrap <= c & (hi_src==8'hFF). Both flags are valid one cycle after the update and last exactly one cycle unless the condition repeats.
- Output latency: tristate outputs are combinational from current register state and enables. Zero-cycle enable-to-drive; values change only after the posedge that updates the PC.
- DB conflict: if opcl_db=1 and opch_db=1 together, databs carries PCL (PCL has priority). This is a control error, but the output is still defined.
- Reading and loading in the same cycle: outputs show the old PC until the edge, so PC can be driven onto ADL while being loaded from it.
- Reset asserted mid-increment: state goes immediately to RESET_PC. The first edge after rstn rises applies normal next-state rules.

Test Plan:
- Reset: rstn=0 with opcl_al=opch_ah=1 -> addrlow=8'hFC, addrhi=8'hFF, pgx=0, pcwrap=0; all enables 0 -> all outputs 8'hzz.
- Sequential fetch: from PC=16'h80FE, inc=1 for 3 clocks -> PC=80FF, 8100 (pgx=1 next cycle), 8101 (pgx=0).
- Jump load: adl_in=8'h34, adh_in=8'h12, ladl=ladh=1, inc=0 -> PC=16'h1234. Next cycle inc=1 -> 16'h1235.
- Load-with-increment carry: adl_in=8'hFF, adh_in=8'h12, ladl=ladh=inc=1 -> PC=16'h1300, pgx=1.
- Wrap: PC=16'hFFFF, inc=1 -> PC=16'h0000, pgx=1, pcwrap=1. Hold a cycle -> both flags 0.
- DB drive/conflict: PC=16'hABCD; opch_db=1 -> databs=8'hAB; opcl_db=opch_db=1 -> databs=8'hCD. Assert rstn=0 mid-sequence between edges -> PC=RESET_PC immediately.
